// File: rtl/ahblite_param_interconnect.sv
// ---------------------------------------------------------------------------
// ahblite_param_interconnect
//
// Single-master AHB-Lite interconnect. The address phase is decoded against a
// base/mask table into a one-hot slave select (lowest index wins on overlap).
// The select is registered on every HREADY=1 cycle and steers the data-phase
// response mux. Unmapped NONSEQ/SEQ transfers are answered by a built-in
// default slave with the two-cycle ERROR response, and each such fault is
// logged in a saturating counter plus a last-error-address register.
//
// Default slave FSM:
//   state   | meaning
//   --------+---------------------------------------------------------------
//   ST_OK   | idle / zero-wait OKAY for IDLE, BUSY or unmapped-but-idle cycles
//   ST_ERR1 | first ERROR cycle: HREADY=0, HRESP=1
//   ST_ERR2 | second ERROR cycle: HREADY=1, HRESP=1
//
// Ports:
//   HCLK, HRESET                clock, synchronous active-high reset
//   HADDR..HWDATA               master address/control/write data (slaves tap
//                               these directly from the master bus)
//   HREADY, HRESP, HRDATA       data-phase response to the master
//   HSEL_S                      one-hot address-phase slave select
//   HREADY_S                    HREADY broadcast to the slaves
//   HREADYOUT_S, HRESP_S,
//   HRDATA_S                    per-slave responses (slave i at [i*DATA_W +: DATA_W])
//   ERR_CNT, ERR_ADDR           decode-error log
// ---------------------------------------------------------------------------
module ahblite_param_interconnect #(
  parameter int                   NSLAVE      = 8,
  parameter int                   DATA_W      = 32,
  parameter logic [NSLAVE*32-1:0] SLV_BASE    = (NSLAVE*32)'({
    32'hF000_0000, 32'hE000_0000, 32'hD000_0000, 32'hC000_0000,
    32'hB000_0000, 32'hA000_0000, 32'h9000_0000, 32'h8000_0000,
    32'h7000_0000, 32'h6000_0000, 32'h5000_0000, 32'h4000_0000,
    32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000}),
  parameter logic [NSLAVE*32-1:0] SLV_MASK    = {NSLAVE{32'hF000_0000}},
  // Saturation ceiling of the decode-error counter.
  parameter logic [15:0]          ERR_CNT_MAX = 16'hFFFF
) (
  input  logic                     HCLK,
  input  logic                     HRESET,
  input  logic [31:0]              HADDR,
  input  logic [1:0]               HTRANS,
  input  logic                     HWRITE,
  input  logic [2:0]               HSIZE,
  input  logic [2:0]               HBURST,
  input  logic [3:0]               HPROT,
  input  logic                     HMASTLOCK,
  input  logic [DATA_W-1:0]        HWDATA,
  output logic                     HREADY,
  output logic                     HRESP,
  output logic [DATA_W-1:0]        HRDATA,
  output logic [NSLAVE-1:0]        HSEL_S,
  output logic                     HREADY_S,
  input  logic [NSLAVE-1:0]        HREADYOUT_S,
  input  logic [NSLAVE-1:0]        HRESP_S,
  input  logic [NSLAVE*DATA_W-1:0] HRDATA_S,
  output logic [15:0]              ERR_CNT,
  output logic [31:0]              ERR_ADDR
);

  if (NSLAVE < 1 || NSLAVE > 16) begin : g_bad_nslave
    $error("NSLAVE must be in 1..16");
  end
  if (DATA_W != 32 && DATA_W != 64) begin : g_bad_data_w
    $error("DATA_W must be 32 or 64");
  end

  typedef enum logic [1:0] {
    ST_OK   = 2'd0,
    ST_ERR1 = 2'd1,
    ST_ERR2 = 2'd2
  } dflt_state_t;

  // Top bit of the registered select marks the default slave.
  localparam logic [NSLAVE:0] SEL_DFLT = {1'b1, {NSLAVE{1'b0}}};

  logic [NSLAVE-1:0] match;
  logic [NSLAVE-1:0] hsel;
  logic              hit;
  logic [NSLAVE:0]   sel_q;
  dflt_state_t       state_q;
  dflt_state_t       state_d;
  logic              dflt_ready;
  logic              dflt_resp;
  logic              hready;
  logic              hresp;
  logic [DATA_W-1:0] hrdata;
  logic              err_start;
  logic [15:0]       err_cnt_q;
  logic [31:0]       err_addr_q;

  // Address decode, independent of HTRANS.
  always_comb begin
    match = '0;
    for (int i = 0; i < NSLAVE; i++) begin
      match[i] = ((HADDR & SLV_MASK[i*32 +: 32]) == SLV_BASE[i*32 +: 32]);
    end
  end

  // Walk from the top down so the lowest matching index is written last.
  always_comb begin
    hsel = '0;
    for (int i = NSLAVE - 1; i >= 0; i--) begin
      if (match[i]) begin
        hsel    = '0;
        hsel[i] = 1'b1;
      end
    end
  end

  assign hit = |match;

  // Data-phase response mux, purely combinational from sel_q.
  always_comb begin
    hready = 1'b1;
    hresp  = 1'b0;
    hrdata = '0;
    if (sel_q[NSLAVE]) begin
      hready = dflt_ready;
      hresp  = dflt_resp;
    end else begin
      for (int i = 0; i < NSLAVE; i++) begin
        if (sel_q[i]) begin
          hready = HREADYOUT_S[i];
          hresp  = HRESP_S[i];
          hrdata = HRDATA_S[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  // An unmapped NONSEQ/SEQ is only taken when the bus actually accepts the
  // address phase; this also makes changes to HTRANS during ERR1 invisible.
  assign err_start = hready & HTRANS[1] & ~hit;

  // Default-slave outputs depend on state only; kept apart from the next-state
  // logic because err_start already depends on them through HREADY.
  always_comb begin
    dflt_ready = 1'b1;
    dflt_resp  = 1'b0;
    case (state_q)
      ST_ERR1: begin
        dflt_ready = 1'b0;
        dflt_resp  = 1'b1;
      end
      ST_ERR2: begin
        dflt_resp  = 1'b1;
      end
      default: begin
        dflt_ready = 1'b1;
        dflt_resp  = 1'b0;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_OK:   if (err_start) state_d = ST_ERR1;
      ST_ERR1: state_d = ST_ERR2;
      ST_ERR2: state_d = err_start ? ST_ERR1 : ST_OK;
      default: state_d = ST_OK;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q    <= ST_OK;
      sel_q      <= SEL_DFLT;
      err_cnt_q  <= '0;
      err_addr_q <= '0;
    end else begin
      state_q <= state_d;
      if (hready) begin
        sel_q <= hit ? {1'b0, hsel} : SEL_DFLT;
      end
      if (err_start) begin
        err_addr_q <= HADDR;
        if (err_cnt_q != ERR_CNT_MAX) begin
          err_cnt_q <= err_cnt_q + 16'd1;
        end
      end
    end
  end

  assign HSEL_S   = hsel;
  assign HREADY   = hready;
  assign HREADY_S = hready;
  assign HRESP    = hresp;
  assign HRDATA   = hrdata;
  assign ERR_CNT  = err_cnt_q;
  assign ERR_ADDR = err_addr_q;

  // Master-side fields that slaves consume directly; the fabric ignores them.
  logic unused_inputs;
  assign unused_inputs = ^{HTRANS[0], HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA};

endmodule
